e203_exu_regfile_mp: RTL and testbench
======================================

Name: e203_exu_regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the EXU. It supports N read ports and M write-back ports, with optional same-cycle write-to-read bypass. It also includes a long-pipe scoreboard that marks destination registers busy while a long-latency op (LSU load, MULDIV) is outstanding. It replaces the single-write, two-read regfile in dual-writeback core configurations.

Parameters:
XLEN, 32, data width.
RFIDX_W, 5, register index width (4 for RV32E).
NREG, 32, number of architectural registers (16 for RV32E); x0 is hardwired zero.
NRD, 2, number of read ports.
NWR, 2, number of write-back ports.
BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns registered state only.
MAX_LPEND, 4, maximum number of outstanding long-pipe destinations.

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous reset, active high.
rd_idx  in  NRD*RFIDX_W  read indices; port k uses slice k.
rd_dat  out  NRD*XLEN  read data per port.
rd_busy  out  NRD  scoreboard busy bit for each read index.
wr_en  in  NWR  write enables.
wr_idx  in  NWR*RFIDX_W  write indices.
wr_dat  in  NWR*XLEN  write data.
wr_lpend_clr  in  NWR  write is a long-pipe completion; clears the busy bit of wr_idx.
lp_set_valid  in  1  request to mark a destination busy.
lp_set_idx  in  RFIDX_W  destination to mark busy.
lp_set_ready  out  1  scoreboard can accept a set request (count < MAX_LPEND).
lp_cnt  out  $clog2(MAX_LPEND+1)  number of busy registers.
lp_empty  out  1  no busy registers (lp_cnt == 0).
x1_r  out  XLEN  current registered value of x1 (return address for the IFU).

Behaviour:
- Reset (async, rst=1): all registers x1..x(NREG-1) = 0 and all busy bits = 0. Outputs: lp_cnt=0, lp_empty=1, lp_set_ready=1, x1_r=0, rd_busy=0. rd_dat reflects zeros.
- Write: on the rising clk, for each port p with wr_en[p]=1 and wr_idx[p] != 0, reg[wr_idx[p]] <= wr_dat[p]. Write latency is 1 cycle.
- Write collision: several ports writing the same index in one cycle -> the highest-numbered port wins. No error flag is raised.
- x0 handling: writes to x0 are dropped, and reads of x0 always return 0, including under bypass.
- Index range: an index >= NREG on read returns 0. On write or set it is ignored.
- Read: purely combinational.
  - BYPASS=1: rd_dat = wr_dat of the highest-numbered port with wr_en and a matching wr_idx, else the registered value.
  - BYPASS=0: rd_dat = the registered value.
- Scoreboard set: lp_set_valid & lp_set_ready & lp_set_idx != 0 -> busy[idx] <= 1 next cycle. Setting an already-busy index is legal and leaves the count unchanged.
- Scoreboard clear: wr_en[p] & wr_lpend_clr[p] -> busy[wr_idx[p]] <= 1'b0. wr_lpend_clr without wr_en is ignored.
- Set and clear of the same index in the same cycle: set wins (a new op is outstanding), so the busy bit stays 1.
- lp_cnt is a registered count of the busy bits. It updates by +1 per accepted new set and -1 per distinct cleared busy index. Two ports clearing the same index decrement by 1 only.
- lp_cnt never exceeds MAX_LPEND and never underflows. A clear of a non-busy index has no effect.
- lp_set_ready = (lp_cnt < MAX_LPEND), combinational from registered state. When lp_set_ready=0, the requester must hold lp_set_valid.
- rd_busy[k] = busy[rd_idx[k]] (registered state). A clear in the current cycle is not bypassed into rd_busy; busy drops the next cycle.
- Reset mid-operation: all state clears immediately, independent of clk.
- Write data is not gated by busy; the caller owns WAW ordering.

Decomposition:
- e203_regfile_pkg holds the shared constants: default XLEN, RFIDX_W, NREG, and a function for the lp_cnt width.
- One sub-module, e203_exu_rf_scoreboard, holds the busy vector, lp_cnt, and the set/clear arbitration.
- Storage, write-priority mux and bypass mux live in the top module.

Test Plan:
1. Reset: assert rst for 2 cycles, then read x1..x31 -> all read 0; lp_empty=1, lp_set_ready=1, x1_r=0.
2. Dual write: port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle -> next-cycle read of x5 = 0x22222222. Same cycle with BYPASS=1 -> rd_dat = 0x22222222. With BYPASS=0 -> old value 0.
3. x0: write x0=0xDEADBEEF with bypass on -> rd_dat for x0 = 0, both the same cycle and the next.
4. Scoreboard fill: set x3, x4, x6, x7 on consecutive cycles -> lp_cnt=4, lp_set_ready=0. Hold a set of x8 -> not accepted. Clear x4 via port1 -> next cycle lp_cnt=3 and lp_set_ready=1, then x8 is accepted.
5. Set/clear race: x9 busy; in one cycle set x9 and clear x9 -> busy[x9]=1 and lp_cnt unchanged. Clear x10 while it is not busy -> lp_cnt unchanged.
6. Async reset mid-run: with lp_cnt=2 and x1=0x80000000, pulse rst between clock edges -> x1_r=0, lp_cnt=0, lp_empty=1 before the next edge.

Source files
------------

// File: rtl/e203_regfile_pkg.sv
// rtl/e203_regfile_pkg.sv - shared constants and helpers for the multi-port EXU regfile
package e203_regfile_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int RFIDX_W_DEF   = 5;
    localparam int NREG_DEF      = 32;
    localparam int NRD_DEF       = 2;
    localparam int NWR_DEF       = 2;
    localparam int MAX_LPEND_DEF = 4;

    // Width needed to hold a count of 0..max_lpend busy destinations.
    function automatic int lpcnt_w(input int max_lpend);
        return $clog2(max_lpend + 1);
    endfunction

    // An index names a writable/readable architectural register: not x0, inside NREG.
    function automatic logic idx_ok(input int idx, input int nreg);
        return (idx != 0) && (idx < nreg);
    endfunction

endpackage

// File: rtl/e203_exu_regfile_mp_if.sv
// rtl/e203_exu_regfile_mp_if.sv - read/write-back/scoreboard bundle of the multi-port regfile
interface e203_exu_regfile_mp_if
    import e203_regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RFIDX_W = RFIDX_W_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int NWR     = NWR_DEF,
    parameter int CNT_W   = lpcnt_w(MAX_LPEND_DEF)
);
    logic [NRD*RFIDX_W-1:0] rd_idx;
    logic [NRD*XLEN-1:0]    rd_dat;
    logic [NRD-1:0]         rd_busy;
    logic [NWR-1:0]         wr_en;
    logic [NWR*RFIDX_W-1:0] wr_idx;
    logic [NWR*XLEN-1:0]    wr_dat;
    logic [NWR-1:0]         wr_lpend_clr;
    logic                   lp_set_valid;
    logic [RFIDX_W-1:0]     lp_set_idx;
    logic                   lp_set_ready;
    logic [CNT_W-1:0]       lp_cnt;
    logic                   lp_empty;
    logic [XLEN-1:0]        x1_r;

    modport master (
        output rd_idx, wr_en, wr_idx, wr_dat, wr_lpend_clr, lp_set_valid, lp_set_idx,
        input  rd_dat, rd_busy, lp_set_ready, lp_cnt, lp_empty, x1_r
    );

    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_dat, wr_lpend_clr, lp_set_valid, lp_set_idx,
        output rd_dat, rd_busy, lp_set_ready, lp_cnt, lp_empty, x1_r
    );

endinterface

// File: rtl/e203_exu_rf_scoreboard.sv
// rtl/e203_exu_rf_scoreboard.sv - long-pipe busy vector, outstanding count and set/clear arbitration
module e203_exu_rf_scoreboard
    import e203_regfile_pkg::*;
#(
    parameter int RFIDX_W   = RFIDX_W_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int NRD       = NRD_DEF,
    parameter int NWR       = NWR_DEF,
    parameter int MAX_LPEND = MAX_LPEND_DEF,
    parameter int CNT_W     = lpcnt_w(MAX_LPEND_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*RFIDX_W-1:0] rd_idx,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*RFIDX_W-1:0] wr_idx,
    input  logic [NWR-1:0]         wr_lpend_clr,
    input  logic                   lp_set_valid,
    input  logic [RFIDX_W-1:0]     lp_set_idx,
    output logic [NRD-1:0]         rd_busy,
    output logic                   lp_set_ready,
    output logic [CNT_W-1:0]       lp_cnt,
    output logic                   lp_empty
);

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  clr_mask;
    logic [NREG-1:0]  set_mask;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] dec;
    logic             inc;

    assign lp_set_ready = (int'(lp_cnt) < MAX_LPEND);
    assign lp_empty     = (lp_cnt == '0);

    // Build set/clear masks; set is OR-ed in after clear so a fresh op on the same index stays busy.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_lpend_clr[p] &&
                idx_ok(int'(wr_idx[p*RFIDX_W +: RFIDX_W]), NREG)) begin
                clr_mask[wr_idx[p*RFIDX_W +: RFIDX_W]] = 1'b1;
            end
        end
        if (lp_set_valid && lp_set_ready && idx_ok(int'(lp_set_idx), NREG)) begin
            set_mask[lp_set_idx] = 1'b1;
        end
        busy_nxt = (busy & ~clr_mask) | set_mask;
    end

    // Count only real transitions: new busy bits up, distinct busy bits actually dropped down.
    always_comb begin
        inc = |(set_mask & ~busy);
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            dec = dec + CNT_W'(clr_mask[i] & busy[i] & ~set_mask[i]);
        end
        cnt_nxt = lp_cnt + CNT_W'(inc) - dec;
    end

    // Busy lookup reflects registered state only; a same-cycle clear shows up next cycle.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (idx_ok(int'(rd_idx[k*RFIDX_W +: RFIDX_W]), NREG)) begin
                rd_busy[k] = busy[rd_idx[k*RFIDX_W +: RFIDX_W]];
            end
        end
    end

    // Busy vector and outstanding count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            lp_cnt <= '0;
        end else begin
            busy   <= busy_nxt;
            lp_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// rtl/e203_exu_regfile_mp.sv - N-read / M-write EXU register file with bypass and long-pipe scoreboard
module e203_exu_regfile_mp
    import e203_regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int RFIDX_W   = RFIDX_W_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int NRD       = NRD_DEF,
    parameter int NWR       = NWR_DEF,
    parameter int BYPASS    = 1,
    parameter int MAX_LPEND = MAX_LPEND_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_exu_regfile_mp_if.slave rf
);

    localparam int CNT_W = lpcnt_w(MAX_LPEND);

    logic [XLEN-1:0] regs [NREG];

    // Register storage; ports are visited in ascending order so the highest-numbered writer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (rf.wr_en[p] && idx_ok(int'(rf.wr_idx[p*RFIDX_W +: RFIDX_W]), NREG)) begin
                    regs[rf.wr_idx[p*RFIDX_W +: RFIDX_W]] <= rf.wr_dat[p*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RFIDX_W-1:0] ri;
        logic [XLEN-1:0]    dat;

        assign ri = rf.rd_idx[k*RFIDX_W +: RFIDX_W];

        // Read mux: x0/out-of-range read zero; bypass picks the highest matching write port.
        always_comb begin
            dat = '0;
            if (idx_ok(int'(ri), NREG)) begin
                dat = regs[ri];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (rf.wr_en[p] && (rf.wr_idx[p*RFIDX_W +: RFIDX_W] == ri)) begin
                            dat = rf.wr_dat[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        assign rf.rd_dat[k*XLEN +: XLEN] = dat;
    end

    assign rf.x1_r = regs[1];

    e203_exu_rf_scoreboard #(
        .RFIDX_W   (RFIDX_W),
        .NREG      (NREG),
        .NRD       (NRD),
        .NWR       (NWR),
        .MAX_LPEND (MAX_LPEND),
        .CNT_W     (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (rf.rd_idx),
        .wr_en        (rf.wr_en),
        .wr_idx       (rf.wr_idx),
        .wr_lpend_clr (rf.wr_lpend_clr),
        .lp_set_valid (rf.lp_set_valid),
        .lp_set_idx   (rf.lp_set_idx),
        .rd_busy      (rf.rd_busy),
        .lp_set_ready (rf.lp_set_ready),
        .lp_cnt       (rf.lp_cnt),
        .lp_empty     (rf.lp_empty)
    );

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// tb/tb_e203_exu_regfile_mp.sv - self-checking bench for e203_exu_regfile_mp (bypass on and off)
module tb_e203_exu_regfile_mp;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_idx = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_idx = '0;
    logic [63:0] wr_dat = '0;
    logic [1:0]  wr_clr = '0;
    logic        set_v = 1'b0;
    logic [4:0]  set_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    e203_exu_regfile_mp_if #(.XLEN(32), .RFIDX_W(5), .NRD(2), .NWR(2), .CNT_W(3)) if_a ();
    e203_exu_regfile_mp_if #(.XLEN(32), .RFIDX_W(5), .NRD(2), .NWR(2), .CNT_W(3)) if_b ();

    assign if_a.rd_idx = rd_idx;        assign if_b.rd_idx = rd_idx;
    assign if_a.wr_en = wr_en;          assign if_b.wr_en = wr_en;
    assign if_a.wr_idx = wr_idx;        assign if_b.wr_idx = wr_idx;
    assign if_a.wr_dat = wr_dat;        assign if_b.wr_dat = wr_dat;
    assign if_a.wr_lpend_clr = wr_clr;  assign if_b.wr_lpend_clr = wr_clr;
    assign if_a.lp_set_valid = set_v;   assign if_b.lp_set_valid = set_v;
    assign if_a.lp_set_idx = set_i;     assign if_b.lp_set_idx = set_i;

    e203_exu_regfile_mp #(.BYPASS(1), .MAX_LPEND(MAXL)) u_dut (.clk(clk), .rst(rst), .rf(if_a));
    e203_exu_regfile_mp #(.BYPASS(0), .MAX_LPEND(MAXL)) u_dut_nb (.clk(clk), .rst(rst), .rf(if_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ri, input bit byp);
        logic [31:0] r;
        if (ri == 5'd0) return 32'h0;
        r = m_reg[ri];
        if (byp)
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && wr_idx[p*5 +: 5] == ri) r = wr_dat[p*32 +: 32];
        return r;
    endfunction

    // Reference model: registers as an array, busy as a set, count as its population.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            bit acc;
            acc = set_v && (m_cnt() < MAXL) && (set_i != 5'd0);
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && wr_clr[p]) m_busy[wr_idx[p*5 +: 5]] = 1'b0;
            if (acc) m_busy[set_i] = 1'b1;
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && wr_idx[p*5 +: 5] != 5'd0) m_reg[wr_idx[p*5 +: 5]] = wr_dat[p*32 +: 32];
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check("rd_dat_byp", 64'(if_a.rd_dat[k*32 +: 32]), 64'(exp_rd(rd_idx[k*5 +: 5], 1'b1)));
                check("rd_dat_nobyp", 64'(if_b.rd_dat[k*32 +: 32]), 64'(exp_rd(rd_idx[k*5 +: 5], 1'b0)));
                check("rd_busy", 64'(if_a.rd_busy[k]), 64'(m_busy[rd_idx[k*5 +: 5]]));
                check("rd_busy_nb", 64'(if_b.rd_busy[k]), 64'(m_busy[rd_idx[k*5 +: 5]]));
            end
            check("lp_cnt", 64'(if_a.lp_cnt), 64'(m_cnt()));
            check("lp_empty", 64'(if_a.lp_empty), 64'(m_cnt() == 0));
            check("lp_set_ready", 64'(if_a.lp_set_ready), 64'(m_cnt() < MAXL));
            check("x1_r", 64'(if_a.x1_r), 64'(m_reg[1]));
            check("x1_r_nb", 64'(if_b.x1_r), 64'(m_reg[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and read-back of every register.
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd_idx = {5'(32 - i), 5'(i)};
            @(negedge clk);
            check("reset_rd0", 64'(if_a.rd_dat[31:0]), 64'h0);
            step();
        end
        @(negedge clk);
        check("reset_empty", 64'(if_a.lp_empty), 64'h1);
        check("reset_ready", 64'(if_a.lp_set_ready), 64'h1);
        check("reset_x1", 64'(if_a.x1_r), 64'h0);
        step();

        // Dual write to x5: higher port wins, with and without bypass.
        rd_idx = {5'd0, 5'd5};
        wr_en = 2'b11; wr_idx = {5'd5, 5'd5}; wr_dat = {32'h22222222, 32'h11111111};
        @(negedge clk);
        check("dual_byp_same", 64'(if_a.rd_dat[31:0]), 64'h22222222);
        check("dual_nobyp_same", 64'(if_b.rd_dat[31:0]), 64'h0);
        step();
        wr_en = 2'b00;
        @(negedge clk);
        check("dual_next", 64'(if_a.rd_dat[31:0]), 64'h22222222);
        check("dual_next_nb", 64'(if_b.rd_dat[31:0]), 64'h22222222);
        step();

        // x0 stays zero, even under bypass.
        rd_idx = {5'd5, 5'd0};
        wr_en = 2'b01; wr_idx = {5'd0, 5'd0}; wr_dat = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        check("x0_same", 64'(if_a.rd_dat[31:0]), 64'h0);
        step();
        wr_en = 2'b00;
        @(negedge clk);
        check("x0_next", 64'(if_a.rd_dat[31:0]), 64'h0);
        step();

        // Scoreboard fill to MAX_LPEND, held set, clear via port1 then acceptance.
        set_v = 1'b1;
        set_i = 5'd3; step();
        set_i = 5'd4; step();
        set_i = 5'd6; step();
        set_i = 5'd7; step();
        set_i = 5'd8; rd_idx = {5'd8, 5'd4};
        @(negedge clk);
        check("fill_cnt", 64'(if_a.lp_cnt), 64'd4);
        check("fill_ready", 64'(if_a.lp_set_ready), 64'h0);
        step();
        @(negedge clk);
        check("held_x8_busy", 64'(if_a.rd_busy[1]), 64'h0);
        step();
        wr_en = 2'b10; wr_idx = {5'd4, 5'd0}; wr_dat = {32'h44, 32'h0}; wr_clr = 2'b10;
        step();
        wr_en = 2'b00; wr_clr = 2'b00;
        @(negedge clk);
        check("clr_cnt", 64'(if_a.lp_cnt), 64'd3);
        check("clr_ready", 64'(if_a.lp_set_ready), 64'h1);
        check("clr_x4_busy", 64'(if_a.rd_busy[0]), 64'h0);
        step();
        set_v = 1'b0;
        @(negedge clk);
        check("x8_cnt", 64'(if_a.lp_cnt), 64'd4);
        check("x8_busy", 64'(if_a.rd_busy[1]), 64'h1);
        step();
        wr_en = 2'b11; wr_idx = {5'd6, 5'd3}; wr_dat = {32'h66, 32'h33}; wr_clr = 2'b11;
        step();
        wr_idx = {5'd8, 5'd7}; wr_dat = {32'h88, 32'h77};
        step();
        wr_en = 2'b00; wr_clr = 2'b00;
        @(negedge clk);
        check("drain_empty", 64'(if_a.lp_empty), 64'h1);
        step();

        // Set/clear race on x9, clear of idle x10, double clear of x9.
        set_v = 1'b1; set_i = 5'd9; rd_idx = {5'd10, 5'd9};
        step();
        wr_en = 2'b01; wr_idx = {5'd0, 5'd9}; wr_dat = {32'h0, 32'h99}; wr_clr = 2'b01;
        step();
        set_v = 1'b0; wr_en = 2'b00; wr_clr = 2'b00;
        @(negedge clk);
        check("race_cnt", 64'(if_a.lp_cnt), 64'd1);
        check("race_busy", 64'(if_a.rd_busy[0]), 64'h1);
        step();
        wr_en = 2'b01; wr_idx = {5'd0, 5'd10}; wr_dat = {32'h0, 32'hA0}; wr_clr = 2'b01;
        step();
        wr_en = 2'b00; wr_clr = 2'b00;
        @(negedge clk);
        check("idle_clr_cnt", 64'(if_a.lp_cnt), 64'd1);
        step();
        wr_en = 2'b11; wr_idx = {5'd9, 5'd9}; wr_dat = {32'h92, 32'h91}; wr_clr = 2'b11;
        step();
        wr_en = 2'b00; wr_clr = 2'b00;
        @(negedge clk);
        check("dbl_clr_cnt", 64'(if_a.lp_cnt), 64'd0);
        step();

        // Asynchronous reset between clock edges.
        set_v = 1'b1; set_i = 5'd2;
        wr_en = 2'b01; wr_idx = {5'd0, 5'd1}; wr_dat = {32'h0, 32'h80000000};
        step();
        set_i = 5'd11; wr_en = 2'b00;
        step();
        set_v = 1'b0;
        @(negedge clk);
        check("pre_rst_cnt", 64'(if_a.lp_cnt), 64'd2);
        check("pre_rst_x1", 64'(if_a.x1_r), 64'h80000000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_x1", 64'(if_a.x1_r), 64'h0);
        check("arst_cnt", 64'(if_a.lp_cnt), 64'd0);
        check("arst_empty", 64'(if_a.lp_empty), 64'h1);
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
